hilo_writeback: RTL and testbench
=================================

Name: hilo_writeback

Overview:
- Downstream companion of the multiply/shift unit.
- Tracks in-flight MULT/MULTU operations through the unit's pipeline and captures the unit's hi/lo outputs into architectural HI and LO registers when they become valid.
- Serves MFHI/MFLO reads and MTHI/MTLO writes from the pipeline.
- Generates the pipeline stall whenever an instruction depends on a multiply that has not yet completed.

Parameters:
- WIDTH, 32, data width of HI, LO and all data ports.
- MUL_LATENCY, 1, cycles from accepted start until mul_hi/mul_lo are valid; legal range 1..7.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- mul_start  input  1  MULT/MULTU issued to the multiply unit this cycle
- squashn  input  1  active-low squash of the instruction in the issue stage
- mul_hi  input  WIDTH  hi output of the multiply unit
- mul_lo  input  WIDTH  lo output of the multiply unit
- mf_req  input  1  MFHI/MFLO read request
- mf_sel  input  1  0 = read LO, 1 = read HI
- mt_we  input  1  MTHI/MTLO write request
- mt_sel  input  1  0 = write LO, 1 = write HI
- mt_data  input  WIDTH  MTHI/MTLO write data
- rd_data  output  WIDTH  MFHI/MFLO result
- hi_q  output  WIDTH  architectural HI register
- lo_q  output  WIDTH  architectural LO register
- busy  output  1  a multiply is in flight
- stall  output  1  hold the requesting pipeline stage

Behaviour:
- Reset: asynchronous, active when resetn=0. Clears hi_q, lo_q, the countdown counter cnt (3 bits), busy and stall. rd_data is then 0.
- busy = (cnt != 0).
- Accept condition: accept = mul_start & squashn & ~busy.
  - On accept, cnt loads MUL_LATENCY.
  - A squashed start (squashn=0) is ignored entirely.
- Countdown: while cnt != 0, cnt decrements by 1 each cycle.
- Completion cycle: the cycle with cnt == 1.
  - mul_hi and mul_lo are valid in this cycle.
  - hi_q and lo_q load them at the closing edge.
  - With MUL_LATENCY=1: start accepted in cycle T, capture at the end of T+1, new values visible from T+2.
- Once accepted, a multiply always completes; squashn does not cancel it.
- Stall: stall = busy & (mul_start | mt_we | mf_req_unserved). stall is combinational.
  - A second start while busy is held, not accepted.
  - An MT while busy is held, which preserves program order. The MT write never collides with a capture.
- MF read:
  - When not busy: rd_data = mf_sel ? hi_q : lo_q.
  - When busy: mf_req_unserved=1 (subject to the forwarding rule below), stall=1, and rd_data is don't-care.
- MT write: when mt_we & ~busy, the selected register loads mt_data at the clock edge. The other register is unchanged.
- Same-cycle MT and MF to the same register (not busy): rd_data returns the old value. The new value is visible the next cycle.
- Same-cycle MT and mul_start (not busy): the multiply is accepted. The MT write takes effect this edge and is overwritten by the later capture.
- Counter is only loaded on accept, so no wrap-around is possible.
- Reset during flight: cnt clears and the pending capture is lost.

Optional Feature:
- Macro: HILO_FWD_EN.
- Defined: in the completion cycle (cnt == 1), an MF request is served by forwarding, with no stall.
  - rd_data = mf_sel ? mul_hi : mul_lo.
  - mf_req_unserved=0.
- Undefined: MF stalls for the completion cycle too and reads hi_q/lo_q the following cycle. This is one extra stall cycle per dependent read.

Test Plan:
- Reset: resetn=0 mid-run with cnt=1 → hi_q=lo_q=0, busy=0, stall=0 immediately (asynchronously); no capture occurs after release.
- MULT, MUL_LATENCY=1: mul_start=1 at T; mul_hi=32'h0000_0001, mul_lo=32'hFFFF_FFFE at T+1 → busy=1 at T+1, hi_q=1, lo_q=32'hFFFF_FFFE at T+2, busy=0.
- Dependent MFHI, MUL_LATENCY=3:
  - MF at T+1 → stall=1 in T+1..T+2.
  - With HILO_FWD_EN: stall=0 at T+3 and rd_data=mul_hi.
  - Without HILO_FWD_EN: stall through T+3; rd_data=hi_q at T+4.
- Squash: mul_start=1, squashn=0, mul_hi=32'hDEAD_BEEF → busy stays 0; hi_q unchanged.
- MTLO during flight: mt_we=1, mt_sel=0, mt_data=32'h1234 at T+1, MUL_LATENCY=2 → stall=1 at T+1 and T+2; after capture, the MT writes and lo_q=32'h1234 while hi_q holds mul_hi.
- Back-to-back starts, MUL_LATENCY=2: second mul_start in T+1 → stall=1 in T+1..T+2; accepted at T+3; its capture at the end of T+5.

Source files
------------

// File: rtl/hilo_writeback.sv
// HI/LO architectural registers with multiply-completion capture, MF/MT service and hazard stall.
// Optional macro HILO_FWD_EN: forward mul_hi/mul_lo to MF reads in the completion cycle.
module hilo_writeback #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mul_start,
    input  logic             squashn,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    input  logic             mf_req,
    input  logic             mf_sel,
    input  logic             mt_we,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic             busy,
    output logic             stall
);

    localparam logic [2:0] LAT = 3'(MUL_LATENCY);

    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic w_busy;
    logic w_accept;
    logic w_complete;
    logic w_fwd;
    logic w_mf_unserved;
    logic w_mt_write;

    assign w_busy     = (r_cnt != 3'd0);
    assign w_accept   = mul_start & squashn & ~w_busy;
    assign w_complete = (r_cnt == 3'd1);
    assign w_mt_write = mt_we & ~w_busy;

`ifdef HILO_FWD_EN
    assign w_fwd = w_complete;
`else
    assign w_fwd = 1'b0;
`endif

    assign w_mf_unserved = mf_req & w_busy & ~w_fwd;
    assign stall         = w_busy & (mul_start | mt_we | w_mf_unserved);
    assign busy          = w_busy;
    assign hi_q          = r_hi;
    assign lo_q          = r_lo;

    always_comb begin
        rd_data = mf_sel ? r_hi : r_lo;
        if (w_fwd) begin
            rd_data = mf_sel ? mul_hi : mul_lo;
        end
    end

    // Counter only loads on accept, which requires idle, so it never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= 3'd0;
        end else if (w_accept) begin
            r_cnt <= LAT;
        end else if (w_busy) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Capture and MT are mutually exclusive: MT only writes when idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_complete) begin
            r_hi <= mul_hi;
            r_lo <= mul_lo;
        end else if (w_mt_write) begin
            if (mt_sel) begin
                r_hi <= mt_data;
            end else begin
                r_lo <= mt_data;
            end
        end
    end

endmodule

// File: tb/tb_hilo_writeback.sv
// Bench for hilo_writeback: three instances (latency 1, 2, 3) share stimulus and are checked
// every cycle against a time-stamped completion model, plus directed literal expectations.
module tb_hilo_writeback;

`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        mul_start;
    logic        squashn;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        mf_req;
    logic        mf_sel;
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] mt_data;

    logic [31:0] rd_o    [3];
    logic [31:0] hi_o    [3];
    logic [31:0] lo_o    [3];
    logic        busy_o  [3];
    logic        stall_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    hilo_writeback #(.WIDTH(32), .MUL_LATENCY(1)) d1 (
        .clk(clk), .resetn(resetn), .mul_start(mul_start), .squashn(squashn),
        .mul_hi(mul_hi), .mul_lo(mul_lo), .mf_req(mf_req), .mf_sel(mf_sel),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .rd_data(rd_o[0]), .hi_q(hi_o[0]), .lo_q(lo_o[0]), .busy(busy_o[0]), .stall(stall_o[0]));

    hilo_writeback #(.WIDTH(32), .MUL_LATENCY(2)) d2 (
        .clk(clk), .resetn(resetn), .mul_start(mul_start), .squashn(squashn),
        .mul_hi(mul_hi), .mul_lo(mul_lo), .mf_req(mf_req), .mf_sel(mf_sel),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .rd_data(rd_o[1]), .hi_q(hi_o[1]), .lo_q(lo_o[1]), .busy(busy_o[1]), .stall(stall_o[1]));

    hilo_writeback #(.WIDTH(32), .MUL_LATENCY(3)) d3 (
        .clk(clk), .resetn(resetn), .mul_start(mul_start), .squashn(squashn),
        .mul_hi(mul_hi), .mul_lo(mul_lo), .mf_req(mf_req), .mf_sel(mf_sel),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .rd_data(rd_o[2]), .hi_q(hi_o[2]), .lo_q(lo_o[2]), .busy(busy_o[2]), .stall(stall_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a multiply accepted in cycle c keeps the unit busy in cycles c+1..c+LAT and
    // lands in HI/LO at the end of cycle c+LAT.
    int          lat    [3] = '{1, 2, 3};
    logic [31:0] m_hi   [3];
    logic [31:0] m_lo   [3];
    bit          m_pend [3];
    int          m_done [3];
    int          cyc = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!resetn) begin
                m_hi[k]   = '0;
                m_lo[k]   = '0;
                m_pend[k] = 1'b0;
                chk($sformatf("L%0d reset hi_q", lat[k]), hi_o[k], 32'h0);
                chk($sformatf("L%0d reset lo_q", lat[k]), lo_o[k], 32'h0);
                chk($sformatf("L%0d reset busy", lat[k]), 32'(busy_o[k]), 32'h0);
                chk($sformatf("L%0d reset stall", lat[k]), 32'(stall_o[k]), 32'h0);
                chk($sformatf("L%0d reset rd_data", lat[k]), rd_o[k], 32'h0);
            end else begin
                bit busy_e, comp, served;
                busy_e = m_pend[k];
                comp   = m_pend[k] && (cyc == m_done[k]);
                served = !busy_e || (FWD && comp);
                chk($sformatf("L%0d hi_q", lat[k]), hi_o[k], m_hi[k]);
                chk($sformatf("L%0d lo_q", lat[k]), lo_o[k], m_lo[k]);
                chk($sformatf("L%0d busy", lat[k]), 32'(busy_o[k]), 32'(busy_e));
                chk($sformatf("L%0d stall", lat[k]), 32'(stall_o[k]),
                    32'(busy_e && (mul_start || mt_we || (mf_req && !served))));
                if (mf_req) begin
                    if (!busy_e)
                        chk($sformatf("L%0d rd_data", lat[k]), rd_o[k], mf_sel ? m_hi[k] : m_lo[k]);
                    else if (FWD && comp)
                        chk($sformatf("L%0d rd_data fwd", lat[k]), rd_o[k], mf_sel ? mul_hi : mul_lo);
                end
                if (comp) begin
                    m_hi[k]   = mul_hi;
                    m_lo[k]   = mul_lo;
                    m_pend[k] = 1'b0;
                end else if (!busy_e) begin
                    if (mt_we) begin
                        if (mt_sel) m_hi[k] = mt_data;
                        else        m_lo[k] = mt_data;
                    end
                    if (mul_start && squashn) begin
                        m_pend[k] = 1'b1;
                        m_done[k] = cyc + lat[k];
                    end
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        resetn = 1'b0; mul_start = 1'b0; squashn = 1'b1;
        mul_hi = '0; mul_lo = '0; mf_req = 1'b0; mf_sel = 1'b0;
        mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0;
        #3;
        chk("por hi_q", hi_o[0], 32'h0);
        chk("por busy", 32'(busy_o[0]), 32'h0);
        chk("por rd_data", rd_o[0], 32'h0);
        #10 resetn = 1'b1;
        idle(2);

        // MULT, latency 1
        mul_start = 1'b1; mul_hi = 32'h0000_0001; mul_lo = 32'hFFFF_FFFE;
        step(); mul_start = 1'b0; #1;
        chk("mult1 busy T+1", 32'(busy_o[0]), 32'h1);
        step(); #1;
        chk("mult1 hi T+2", hi_o[0], 32'h0000_0001);
        chk("mult1 lo T+2", lo_o[0], 32'hFFFF_FFFE);
        chk("mult1 busy T+2", 32'(busy_o[0]), 32'h0);
        idle(4);

        // Dependent MFHI, latency 3
        mul_start = 1'b1; mul_hi = 32'hA5A5_0003; mul_lo = 32'h0000_0B0B;
        step(); mul_start = 1'b0; mf_req = 1'b1; mf_sel = 1'b1; #1;
        chk("mfhi stall T+1", 32'(stall_o[2]), 32'h1);
        step(); #1;
        chk("mfhi stall T+2", 32'(stall_o[2]), 32'h1);
        step(); #1;
        chk("mfhi stall T+3", 32'(stall_o[2]), FWD ? 32'h0 : 32'h1);
        step(); #1;
        chk("mfhi stall T+4", 32'(stall_o[2]), 32'h0);
        chk("mfhi rd T+4", rd_o[2], 32'hA5A5_0003);
        step(); mf_req = 1'b0;
        idle(3);

        // Squashed start
        mul_start = 1'b1; squashn = 1'b0; mul_hi = 32'hDEAD_BEEF; mul_lo = 32'hDEAD_BEEF;
        step(); mul_start = 1'b0; squashn = 1'b1; #1;
        chk("squash busy L1", 32'(busy_o[0]), 32'h0);
        chk("squash busy L3", 32'(busy_o[2]), 32'h0);
        chk("squash hi L1", hi_o[0], 32'hA5A5_0003);
        step(); #1;
        chk("squash hi L3", hi_o[2], 32'hA5A5_0003);
        idle(2);

        // MTLO during flight, latency 2
        mul_start = 1'b1; mul_hi = 32'hC0C0_C0C0; mul_lo = 32'h0D0D_0D0D;
        step(); mul_start = 1'b0; mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_1234; #1;
        chk("mtlo stall T+1", 32'(stall_o[1]), 32'h1);
        step(); #1;
        chk("mtlo stall T+2", 32'(stall_o[1]), 32'h1);
        step(); #1;
        chk("mtlo stall T+3", 32'(stall_o[1]), 32'h0);
        chk("mtlo lo captured", lo_o[1], 32'h0D0D_0D0D);
        step(); mt_we = 1'b0; #1;
        chk("mtlo lo written", lo_o[1], 32'h0000_1234);
        chk("mtlo hi kept", hi_o[1], 32'hC0C0_C0C0);
        idle(3);

        // Back-to-back starts, latency 2
        mul_start = 1'b1; mul_hi = 32'h0000_00E1; mul_lo = 32'h0000_00F1;
        step(); #1;
        chk("b2b stall T+1", 32'(stall_o[1]), 32'h1);
        step(); #1;
        chk("b2b stall T+2", 32'(stall_o[1]), 32'h1);
        step(); #1;
        chk("b2b stall T+3", 32'(stall_o[1]), 32'h0);
        chk("b2b hi first", hi_o[1], 32'h0000_00E1);
        step(); mul_start = 1'b0; mul_hi = 32'h6666_0001; mul_lo = 32'h0000_4444; #1;
        chk("b2b busy T+4", 32'(busy_o[1]), 32'h1);
        step(); #1;
        chk("b2b hi T+5", hi_o[1], 32'h0000_00E1);
        chk("b2b busy T+5", 32'(busy_o[1]), 32'h1);
        step(); #1;
        chk("b2b hi T+6", hi_o[1], 32'h6666_0001);
        chk("b2b lo T+6", lo_o[1], 32'h0000_4444);
        chk("b2b busy T+6", 32'(busy_o[1]), 32'h0);
        idle(4);

        // Same-cycle MTHI and MFHI: old value first
        mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'h0000_0055; mf_req = 1'b1; mf_sel = 1'b1; #1;
        chk("mt/mf old", rd_o[1], 32'h6666_0001);
        step(); mt_we = 1'b0; #1;
        chk("mt/mf new", rd_o[1], 32'h0000_0055);
        step(); mf_req = 1'b0;
        idle(2);

        // Same-cycle MTHI and start: MT lands, then capture overwrites
        mul_start = 1'b1; mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'h0000_0077;
        mul_hi = 32'h0000_0088; mul_lo = 32'h0000_0099;
        step(); mul_start = 1'b0; mt_we = 1'b0; #1;
        chk("mt+start hi T+1", hi_o[0], 32'h0000_0077);
        chk("mt+start busy T+1", 32'(busy_o[0]), 32'h1);
        step(); #1;
        chk("mt+start hi T+2", hi_o[0], 32'h0000_0088);
        idle(4);

        // Reset while the latency-1 capture is pending
        mul_start = 1'b1; mul_hi = 32'h0000_0999; mul_lo = 32'h0000_0AAA;
        step(); #1;
        resetn = 1'b0; #1;
        chk("rst hi immediate", hi_o[0], 32'h0);
        chk("rst lo immediate", lo_o[0], 32'h0);
        chk("rst busy immediate", 32'(busy_o[0]), 32'h0);
        chk("rst stall immediate", 32'(stall_o[0]), 32'h0);
        mul_start = 1'b0;
        step(); #1;
        resetn = 1'b1;
        idle(2); #1;
        chk("rst no capture L1", hi_o[0], 32'h0);
        chk("rst no capture L3", hi_o[2], 32'h0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
